// File: rtl/switch_conditioner.sv
// Switch conditioner: per-bit synchroniser, debouncer and level/edge outputs feeding picoMIPS SW[9:0].
// Optional SWCOND_AUTOREPEAT_EN adds periodic rise pulses on STEP_BIT while it is held high.
module switch_conditioner #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned STEP_BIT        = 8,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 || STEP_BIT >= WIDTH) begin : g_param_check
        $error("switch_conditioner: parameter out of range");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q, rise_d, rise_evt;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             busy_q, busy_d;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= sw_raw;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Counters stop at CNT_LAST by construction: that value always takes the update branch.
    always_comb begin
        clean_d  = clean_q;
        rise_evt = '0;
        fall_d   = '0;
        busy_d   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_s[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                clean_d[i]  = sync_s[i];
                rise_evt[i] = sync_s[i];
                fall_d[i]   = ~sync_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            busy_d = busy_d | (cnt_d[i] != '0);
        end
    end

`ifdef SWCOND_AUTOREPEAT_EN
    localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_fire;

    // Runs only while the step bit stays high across the edge, so a repeat never coincides with a fall.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (!clean_d[STEP_BIT] || rise_evt[STEP_BIT]) begin
            rep_d = '0;
        end else if (rep_q == REP_LAST) begin
            rep_d    = '0;
            rep_fire = 1'b1;
        end else begin
            rep_d = rep_q + REP_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) rep_q <= '0;
        else         rep_q <= rep_d;
    end

    always_comb begin
        rise_d           = rise_evt;
        rise_d[STEP_BIT] = rise_evt[STEP_BIT] | rep_fire;
    end
`else
    assign rise_d = rise_evt;
`endif

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign sw_clean = clean_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed test-plan steps plus random bouncing inputs vs a window-based model.
module tb_switch_conditioner;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 4;
    localparam int unsigned REP   = 8;
    localparam int unsigned STEP  = 8;
    localparam logic [WIDTH-1:0] STEP_MASK = 10'h100;
`ifdef SWCOND_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic             Clock  = 1'b0;
    logic             nReset = 1'b0;
    logic [WIDTH-1:0] sw_raw = '0;
    logic [WIDTH-1:0] sw_clean, rise, fall;
    logic             busy;

    switch_conditioner #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .STEP_BIT(STEP),
        .REPEAT_CYCLES(REP)
    ) dut (
        .Clock(Clock),
        .nReset(nReset),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: a bit flips once its last DEB synchronised samples all disagree with the clean level.
    logic [WIDTH-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
    logic             m_busy = 1'b0;
    logic [WIDTH-1:0] raw_hist[$];
    logic [WIDTH-1:0] s_hist[$];
    int unsigned      edge_n = 0, last_step = 0;

    task automatic model_edge(input logic rst_n, input logic [WIDTH-1:0] raw);
        logic [WIDTH-1:0] s, prev;
        int unsigned run;
        if (!rst_n) begin
            raw_hist.delete();
            s_hist.delete();
            m_clean = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
            edge_n = 0; last_step = 0;
            return;
        end
        edge_n++;
        s = (raw_hist.size() >= SYNC) ? raw_hist[raw_hist.size() - SYNC] : '0;
        raw_hist.push_back(raw);
        if (raw_hist.size() > SYNC) void'(raw_hist.pop_front());
        s_hist.push_back(s);
        if (s_hist.size() > DEB + 1) void'(s_hist.pop_front());
        prev = m_clean; m_rise = '0; m_fall = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            run = 0;
            for (int k = s_hist.size() - 1; k >= 0; k--) begin
                if (s_hist[k][i] == prev[i]) break;
                run++;
            end
            if (run >= DEB) begin
                m_clean[i] = s[i];
                m_rise[i]  = s[i];
                m_fall[i]  = ~s[i];
            end
        end
`ifdef SWCOND_AUTOREPEAT_EN
        if (m_rise[STEP]) last_step = edge_n;
        else if (prev[STEP] && m_clean[STEP] && (edge_n - last_step == REP)) begin
            m_rise[STEP] = 1'b1;
            last_step    = edge_n;
        end
`endif
        m_busy = |(s ^ m_clean);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge(nReset, sw_raw);
        #1;
        check("clean", sw_clean, m_clean);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("busy", busy, m_busy);
    endtask

    initial begin
        int unsigned      t_hit, cnt_r, cnt_f;
        logic             seen_busy;
        logic [WIDTH-1:0] other;

        // Power-up with all switches high
        nReset = 1'b0; sw_raw = '1;
        repeat (3) begin
            tick();
            check("rst_clean", sw_clean, 0);
            check("rst_rise", rise, 0);
            check("rst_fall", fall, 0);
            check("rst_busy", busy, 0);
        end
        nReset = 1'b1;
        for (int unsigned t = 1; t <= 5; t++) begin
            tick();
            check("pu_early", sw_clean, 0);
        end
        tick();
        check("pu_clean", sw_clean, 10'h3FF);
        check("pu_rise", rise, 10'h3FF);
        tick();
        check("pu_rise_once", rise, 0);
        sw_raw = '0;
        repeat (10) tick();

        // Longest rejectable glitch on bit 0
        seen_busy = 1'b0;
        sw_raw[0] = 1'b1;
        repeat (3) begin tick(); seen_busy |= busy; end
        sw_raw[0] = 1'b0;
        repeat (8) begin
            tick();
            seen_busy |= busy;
            check("gl_clean", sw_clean, 0);
            check("gl_rise", rise, 0);
            check("gl_fall", fall, 0);
        end
        check("gl_busy_seen", seen_busy, 1);
        check("gl_busy_end", busy, 0);

        // Clean press and release of the step bit
        sw_raw[STEP] = 1'b1; t_hit = 0; cnt_r = 0; other = '0;
        for (int unsigned t = 1; t <= 20; t++) begin
            tick();
            if (sw_clean[STEP] && t_hit == 0) t_hit = t;
            if (rise[STEP]) cnt_r++;
            other |= (sw_clean | rise | fall) & ~STEP_MASK;
        end
        check("p_rise_lat", t_hit, 6);
        check("p_rise_cnt", cnt_r, AR ? 2 : 1);
        sw_raw[STEP] = 1'b0; t_hit = 0; cnt_f = 0;
        for (int unsigned t = 1; t <= 12; t++) begin
            tick();
            if (!sw_clean[STEP] && t_hit == 0) t_hit = t;
            if (fall[STEP]) cnt_f++;
            other |= (sw_clean | rise | fall) & ~STEP_MASK;
        end
        check("p_fall_lat", t_hit, 6);
        check("p_fall_cnt", cnt_f, 1);
        check("p_others", other, 0);

        // Bounce on bit 3, then stable high
        t_hit = 0; cnt_r = 0;
        for (int unsigned t = 0; t < 20; t++) begin
            sw_raw[3] = ((t / 2) % 2 == 0);
            tick();
            if (rise[3]) cnt_r++;
        end
        check("b_no_early", cnt_r, 0);
        sw_raw[3] = 1'b1;
        for (int unsigned t = 1; t <= 12; t++) begin
            tick();
            if (rise[3]) begin
                cnt_r++;
                if (t_hit == 0) t_hit = t;
            end
        end
        check("b_lat", t_hit, 6);
        check("b_cnt", cnt_r, 1);
        sw_raw[3] = 1'b0;
        repeat (10) tick();

        // Reset in the middle of a count on bit 5
        sw_raw[5] = 1'b1;
        repeat (4) tick();
        check("r_pre", sw_clean[5], 0);
        nReset = 1'b0;
        tick();
        check("r_busy", busy, 0);
        nReset = 1'b1; t_hit = 0;
        for (int unsigned t = 1; t <= 12; t++) begin
            tick();
            if (sw_clean[5] && t_hit == 0) t_hit = t;
        end
        check("r_lat", t_hit, 6);
        sw_raw[5] = 1'b0;
        repeat (10) tick();

        // Held step button
        sw_raw[STEP] = 1'b1; t_hit = 0;
        for (int unsigned t = 1; t <= 20; t++) begin
            tick();
            if (rise[STEP]) begin t_hit = t; break; end
        end
        check("ar_first", t_hit, 6);
        cnt_r = 0; t_hit = 0;
        for (int unsigned t = 1; t <= 30; t++) begin
            tick();
            if (rise[STEP]) begin
                cnt_r++;
                if (t_hit == 0) t_hit = t;
            end
        end
        check("ar_cnt", cnt_r, AR ? 3 : 0);
        check("ar_first_rep", t_hit, AR ? 8 : 0);
        sw_raw[STEP] = 1'b0;
        repeat (10) tick();

        // Random bouncing levels with occasional resets
        for (int unsigned n = 0; n < 800; n++) begin
            logic [WIDTH-1:0] flip;
            flip = '0;
            for (int unsigned b = 0; b < WIDTH; b++)
                if ($urandom_range(b == STEP ? 19 : 5) == 0) flip[b] = 1'b1;
            sw_raw = sw_raw ^ flip;
            nReset = ($urandom_range(99) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
